// File: rtl/axi_rr_arbiter.sv
// N-requester grant arbiter for AXI address/write-data channels.
// Grant is held until owner completes; zero-bubble handover between requesters.
module axi_rr_arbiter #(
    parameter int N_REQ        = 4,
    parameter int LOCK_ON_LAST = 1,
    parameter int PRIO_MODE    = 0,
    localparam int IDX_W       = $clog2(N_REQ)
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic [N_REQ-1:0] req_valid,
    input  logic [N_REQ-1:0] req_ready,
    input  logic [N_REQ-1:0] req_last,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N_REQ-1:0] grant_onehot,
    output logic             proto_err
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [N_REQ-1:0] ONE     = N_REQ'(1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_REQ-1:0] oh_q, oh_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             ovld_q, ovld_d;
    logic             ohs_q, ohs_d;
    logic             perr_q, perr_d;

    logic             own_v;
    logic             own_r;
    logic             own_l;
    logic             done;
    logic [N_REQ-1:0] cand;
    logic [IDX_W-1:0] win;

    // Scan starts just after ptr in round-robin mode, at index 0 otherwise.
    function automatic logic [IDX_W-1:0] pick(
        input logic [N_REQ-1:0] c,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0] w;
        logic             found;
        logic [N_REQ-1:0] sh;
        int               j;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (PRIO_MODE != 0) ? k : int'(ptr) + k + 1;
            if (j >= N_REQ) j = j - N_REQ;
            sh = c >> j;
            if (!found && sh[0]) begin
                w     = IDX_W'(j);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        oh_d    = oh_q;
        last_d  = last_q;
        ovld_d  = ovld_q;
        ohs_d   = ohs_q;
        perr_d  = perr_q;
        own_v   = |(req_valid & oh_q);
        own_r   = |(req_ready & oh_q);
        own_l   = |(req_last & oh_q);
        done    = own_v & own_r & (own_l | (LOCK_ON_LAST == 0));
        cand    = req_valid & ~oh_q;
        win     = '0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    win     = pick(req_valid, last_q);
                    state_d = GRANT;
                    idx_d   = win;
                    oh_d    = ONE << win;
                    ovld_d  = 1'b1;
                    ohs_d   = 1'b0;
                end
            end
            GRANT: begin
                // Owner VALID fell while a beat was still pending.
                if (!own_v && ovld_q && !ohs_q) perr_d = 1'b1;
                if (done) begin
                    last_d = idx_q;
                    if (|cand) begin
                        win    = pick(cand, idx_q);
                        idx_d  = win;
                        oh_d   = ONE << win;
                        ovld_d = 1'b1;
                        ohs_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                        idx_d   = '0;
                        oh_d    = '0;
                        ovld_d  = 1'b0;
                        ohs_d   = 1'b0;
                    end
                end else begin
                    ovld_d = own_v;
                    ohs_d  = own_v & own_r;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= IDLE;
            idx_q   <= '0;
            oh_q    <= '0;
            last_q  <= LAST_RST;
            ovld_q  <= 1'b0;
            ohs_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            oh_q    <= oh_d;
            last_q  <= last_d;
            ovld_q  <= ovld_d;
            ohs_q   <= ohs_d;
            perr_q  <= perr_d;
        end
    end

    assign grant_valid  = (state_q == GRANT);
    assign grant_idx    = idx_q;
    assign grant_onehot = oh_q;
    assign proto_err    = perr_q;

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Directed bench for axi_rr_arbiter: RR, lock-on-last, fixed priority,
// protocol error, async reset and non-power-of-two wrap.
module tb_axi_rr_arbiter;

    logic       clk;
    logic       rst_n;

    logic [3:0] a_v, a_r, a_l;
    logic       a_gv, a_pe;
    logic [1:0] a_idx;
    logic [3:0] a_oh;

    logic [3:0] b_v, b_r, b_l;
    logic       b_gv, b_pe;
    logic [1:0] b_idx;
    logic [3:0] b_oh;

    logic [2:0] c_v, c_r, c_l;
    logic       c_gv, c_pe;
    logic [1:0] c_idx;
    logic [2:0] c_oh;

    int checks = 0;
    int errors = 0;

    axi_rr_arbiter #(.N_REQ(4), .LOCK_ON_LAST(1), .PRIO_MODE(0)) dut_a (
        .ACLK(clk), .ARESETn(rst_n),
        .req_valid(a_v), .req_ready(a_r), .req_last(a_l),
        .grant_valid(a_gv), .grant_idx(a_idx),
        .grant_onehot(a_oh), .proto_err(a_pe)
    );

    axi_rr_arbiter #(.N_REQ(4), .LOCK_ON_LAST(1), .PRIO_MODE(1)) dut_b (
        .ACLK(clk), .ARESETn(rst_n),
        .req_valid(b_v), .req_ready(b_r), .req_last(b_l),
        .grant_valid(b_gv), .grant_idx(b_idx),
        .grant_onehot(b_oh), .proto_err(b_pe)
    );

    axi_rr_arbiter #(.N_REQ(3), .LOCK_ON_LAST(0), .PRIO_MODE(0)) dut_c (
        .ACLK(clk), .ARESETn(rst_n),
        .req_valid(c_v), .req_ready(c_r), .req_last(c_l),
        .grant_valid(c_gv), .grant_idx(c_idx),
        .grant_onehot(c_oh), .proto_err(c_pe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic gv,
                         input logic [1:0] idx, input logic [3:0] oh);
        chk({tag, ".gv"}, 32'(a_gv), 32'(gv));
        chk({tag, ".idx"}, 32'(a_idx), 32'(idx));
        chk({tag, ".oh"}, 32'(a_oh), 32'(oh));
    endtask

    initial begin
        rst_n = 1'b0;
        a_v = '0; a_r = '0; a_l = '0;
        b_v = '0; b_r = '0; b_l = '0;
        c_v = '0; c_r = '0; c_l = '0;
        #12;
        chk_a("rst_a", 1'b0, 2'd0, 4'h0);
        chk("rst_a.pe", 32'(a_pe), 32'd0);
        chk("rst_b.gv", 32'(b_gv), 32'd0);
        chk("rst_c.gv", 32'(c_gv), 32'd0);
        rst_n = 1'b1;

        // RR: all four valid, single-beat transfers
        a_v = 4'b1111; a_l = 4'b1111; a_r = 4'b0000;
        step();
        chk_a("rr0", 1'b1, 2'd0, 4'b0001);
        a_r = 4'b0001;
        step();
        chk_a("rr1", 1'b1, 2'd1, 4'b0010);
        a_r = 4'b0010;
        step();
        chk_a("rr2", 1'b1, 2'd2, 4'b0100);
        a_r = 4'b0100;
        step();
        chk_a("rr3", 1'b1, 2'd3, 4'b1000);
        a_r = 4'b1000;
        step();
        chk_a("rr4", 1'b1, 2'd0, 4'b0001);
        a_v = 4'b0001; a_r = 4'b0001;
        step();
        chk_a("rr_idle", 1'b0, 2'd0, 4'b0000);

        // Lock on last: owner 1 sends 4 beats, req 2 waiting
        a_v = 4'b0110; a_r = 4'b0000; a_l = 4'b0000;
        step();
        chk_a("lk_g", 1'b1, 2'd1, 4'b0010);
        a_r = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_a("lk_beat", 1'b1, 2'd1, 4'b0010);
        end
        a_l = 4'b0010;
        step();
        chk_a("lk_hand", 1'b1, 2'd2, 4'b0100);
        a_v = 4'b0100; a_r = 4'b0100; a_l = 4'b0100;
        step();
        chk_a("lk_idle", 1'b0, 2'd0, 4'b0000);

        // Lone requester 3: never regranted back-to-back
        a_v = 4'b1000; a_r = 4'b1000; a_l = 4'b1000;
        step();
        chk_a("solo_g1", 1'b1, 2'd3, 4'b1000);
        step();
        chk_a("solo_gap", 1'b0, 2'd0, 4'b0000);
        step();
        chk_a("solo_g2", 1'b1, 2'd3, 4'b1000);
        step();
        chk_a("solo_idle", 1'b0, 2'd0, 4'b0000);
        chk("solo.pe", 32'(a_pe), 32'd0);

        // Protocol error: owner 2 drops VALID without handshake
        a_v = 4'b0100; a_r = 4'b0000; a_l = 4'b0000;
        step();
        chk_a("pe_g", 1'b1, 2'd2, 4'b0100);
        chk("pe_pre", 32'(a_pe), 32'd0);
        a_v = 4'b0000;
        step();
        chk("pe_set", 32'(a_pe), 32'd1);
        chk_a("pe_hold1", 1'b1, 2'd2, 4'b0100);
        step();
        chk("pe_stick", 32'(a_pe), 32'd1);
        chk_a("pe_hold2", 1'b1, 2'd2, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk_a("arst", 1'b0, 2'd0, 4'b0000);
        chk("arst.pe", 32'(a_pe), 32'd0);
        #2 rst_n = 1'b1;

        // Fixed priority: reqs 1 and 3 alternate via owner masking
        b_v = 4'b1010; b_l = 4'b1111; b_r = 4'b0000;
        step();
        chk("fp0.idx", 32'(b_idx), 32'd1);
        chk("fp0.oh", 32'(b_oh), 32'b0010);
        b_r = 4'b0010;
        step();
        chk("fp1.idx", 32'(b_idx), 32'd3);
        chk("fp1.oh", 32'(b_oh), 32'b1000);
        b_r = 4'b1000;
        step();
        chk("fp2.idx", 32'(b_idx), 32'd1);
        chk("fp2.oh", 32'(b_oh), 32'b0010);
        b_r = 4'b0010;
        step();
        chk("fp3.idx", 32'(b_idx), 32'd3);
        chk("fp3.gv", 32'(b_gv), 32'd1);
        b_v = 4'b1000; b_r = 4'b1000;
        step();
        chk("fp_idle", 32'(b_gv), 32'd0);

        // N_REQ=3, no lock: req 2 then req 0, wrap without index 3
        c_v = 3'b100; c_r = 3'b000; c_l = 3'b000;
        step();
        chk("w3_g2.idx", 32'(c_idx), 32'd2);
        chk("w3_g2.oh", 32'(c_oh), 32'b100);
        c_r = 3'b100;
        step();
        chk("w3_idle", 32'(c_gv), 32'd0);
        c_v = 3'b001; c_r = 3'b001;
        step();
        chk("w3_g0.idx", 32'(c_idx), 32'd0);
        chk("w3_g0.oh", 32'(c_oh), 32'b001);
        step();
        chk("w3_end", 32'(c_gv), 32'd0);
        chk("w3.pe", 32'(c_pe), 32'd0);
        c_v = '0; c_r = '0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/axi_rr_arbiter.md
Name: axi_rr_arbiter

Overview:
- Parametrised N-requester arbiter for the AXI interconnect address and write-data channels.
- Replaces the fixed two-master arbiter.
- Grants one requester at a time and holds the grant until that requester's transfer completes (optionally on the last beat of a burst).
- Hands over back-to-back between different requesters with no bubble; the registered grant index drives the interconnect's payload/ready muxes.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- IDX_W, $clog2(N_REQ), width of grant index (derived; not overridden).
- LOCK_ON_LAST, 1, 1: transfer completes on handshake with req_last=1; 0: completes on any single handshake.
- PRIO_MODE, 0, 0: round-robin; 1: fixed priority, lowest index wins.

Ports:
- ACLK  in  1  clock, all state on rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester VALID.
- req_ready  in  N_REQ  per-requester READY as returned by the interconnect (handshake observe only).
- req_last  in  N_REQ  per-requester LAST (ignored when LOCK_ON_LAST=0).
- grant_valid  out  1  a requester currently owns the channel.
- grant_idx  out  IDX_W  index of owner; valid only when grant_valid=1.
- grant_onehot  out  N_REQ  one-hot of owner; all zero when grant_valid=0.
- proto_err  out  1  sticky: owner dropped VALID mid-transfer without handshake.

Behaviour:
- Reset (async assert, sync release) values:
  - grant_valid=0, grant_idx=0, grant_onehot=0, proto_err=0.
  - Internal last_idx=N_REQ-1, so index 0 has first round-robin priority.
- All outputs are registered; no combinational path from inputs to outputs.
- States:
  - IDLE: grant_valid=0.
  - GRANT: grant_valid=1, owner g=grant_idx.
- IDLE:
  - If any req_valid, select a winner and go to GRANT next cycle (1-cycle request-to-grant latency).
  - Otherwise stay in IDLE.
- Winner selection:
  - Round-robin: first set bit scanning last_idx+1, last_idx+2, ... with wrap modulo N_REQ.
  - Fixed priority: lowest set index.
- GRANT, completion condition: req_valid[g] & req_ready[g] & (req_last[g] | !LOCK_ON_LAST).
- On completion:
  - last_idx <= g.
  - Candidate set = req_valid with bit g cleared.
  - Candidate set non-empty: select winner from it using the active mode; stay in GRANT with the new owner next cycle (zero-bubble handover).
  - Candidate set empty: go to IDLE. The same requester can re-win from IDLE after one idle cycle, so there is never an unconditional back-to-back self-regrant.
- GRANT, no completion:
  - Hold g; non-owner valid/ready/last are ignored.
  - Non-final beats (handshake with last=0, LOCK_ON_LAST=1) keep the grant.
- A grant is never revoked before completion.
- If req_valid[g] falls while in GRANT without a handshake on the previous cycle, proto_err <= 1. proto_err clears only on reset; the grant is still held.
- Multiple simultaneous requests: exactly one winner per selection; grant_onehot always equals 1<<grant_idx when grant_valid=1.
- Reset mid-burst: immediate return to IDLE with reset values; the burst is abandoned.
- N_REQ not a power of two: indices >= N_REQ are never produced; wrap goes from N_REQ-1 to 0.

Test Plan:
- N_REQ=4, RR: req_valid=4'b1111 from reset, each does a single-beat last=1 handshake when granted → grant_idx sequence 0,1,2,3,0 with grant_valid continuously 1 after the first cycle.
- LOCK_ON_LAST=1: owner 1 sends 4 beats (last on beat 4) while req 2 is valid throughout → grant_idx stays 1 through beat 4, becomes 2 on the cycle after beat 4.
- Only req 3 valid, two consecutive single-beat transfers → grant 3, one cycle grant_valid=0, grant 3 again.
- PRIO_MODE=1, reqs 1 and 3 continuously valid, single beats → grants alternate 1,3,1,3 (masking of owner), never 0 or 2.
- Owner 2 drops req_valid without ready → proto_err=1 next cycle and stays 1; grant_idx remains 2; ARESETn pulse clears all outputs to 0.
- N_REQ=3, RR with only req 2 then req 0 valid → wrap 2→0 with no grant_idx=3 ever observed.
